// File: rtl/motor_pkg.sv
// Shared types and constants for the stepper motion sequencer:
// FSM states, speed divisor table and full-step coil patterns.
package motor_pkg;

    localparam int DIV_W = 20;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CONT    = 2'd1,
        ST_QUARTER = 2'd2,
        ST_HOLD    = 2'd3
    } state_t;

    typedef logic [3:0][DIV_W-1:0] div_table_t;

    localparam logic [DIV_W-1:0] DIV_ONE = {{(DIV_W-1){1'b0}}, 1'b1};

    // Index 0 is the slowest rate: 100, 200, 400, 800 steps/s at 50 MHz.
    localparam div_table_t SPEED_DIV = {20'd62500, 20'd125000, 20'd250000, 20'd500000};

    localparam logic [3:0][3:0] PHASE_TABLE = {4'b1001, 4'b1100, 4'b0110, 4'b0011};

    function automatic logic [3:0] phase_coils(input logic [1:0] idx);
        return PHASE_TABLE[idx];
    endfunction

    function automatic logic [1:0] phase_step(input logic [1:0] idx, input logic fwd);
        return fwd ? (idx + 2'd1) : (idx - 2'd1);
    endfunction

endpackage

// File: rtl/step_tick_gen.sv
// Step-rate divisor: counts clk cycles and fires a tick every DIV cycles.
// The divisor is only sampled on clear or at a tick, so changes apply at period boundaries.
module step_tick_gen
    import motor_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] cnt_r;
    logic [DIV_W-1:0] div_r;

    assign tick = (cnt_r == (div_r - DIV_ONE));

    // Divisor counter and period latch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= '0;
            div_r <= '0;
        end else if (clear) begin
            cnt_r <= '0;
            div_r <= div;
        end else if (tick) begin
            cnt_r <= '0;
            div_r <= div;
        end else begin
            cnt_r <= cnt_r + DIV_ONE;
        end
    end

endmodule

// File: rtl/motion_sequencer.sv
// Mode sequencer for the stepper: arbitrates continuous motion against a one-shot
// quarter rotation and emits the paced, registered coil phase sequence.
module motion_sequencer
    import motor_pkg::*;
#(
    parameter int         QUARTER_STEPS = 50,
    parameter int         TICK_DIV_OVR  = 0,
    parameter div_table_t SPEED_TABLE   = SPEED_DIV
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       on_switch,
    input  logic       quarter_req,
    input  logic       dir,
    input  logic [1:0] speed_sel,
    output logic [3:0] coils,
    output logic       step_pulse,
    output logic       quarter_active,
    output logic       motor_enable,
    output logic [7:0] steps_left
);

    localparam logic [7:0]       QS_L  = 8'(QUARTER_STEPS);
    localparam logic [DIV_W-1:0] OVR_L = DIV_W'(TICK_DIV_OVR);

    state_t           state_r;
    state_t           state_next_s;
    logic [1:0]       phase_r;
    logic [1:0]       phase_next_s;
    logic [7:0]       steps_left_r;
    logic [7:0]       steps_left_next_s;
    logic             qr_prev_r;
    logic             qr_rise_s;
    logic             step_s;
    logic             clear_s;
    logic             tick_s;
    logic [DIV_W-1:0] div_sel_s;
    logic [3:0]       coils_r;
    logic             step_pulse_r;
    logic             quarter_active_r;

    assign qr_rise_s    = quarter_req & ~qr_prev_r;
    assign div_sel_s    = (OVR_L != '0) ? OVR_L : SPEED_TABLE[speed_sel];
    assign phase_next_s = step_s ? phase_step(phase_r, dir) : phase_r;
    // Restart the period on every state change and keep it parked while idle.
    assign clear_s      = (state_next_s != state_r) || (state_next_s == ST_IDLE);

    step_tick_gen u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear_s),
        .div   (div_sel_s),
        .tick  (tick_s)
    );

    // Next-state, step decision and quarter step bookkeeping
    always_comb begin
        state_next_s      = state_r;
        steps_left_next_s = steps_left_r;
        step_s            = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (on_switch) begin
                    state_next_s = ST_CONT;
                end else if (qr_rise_s) begin
                    state_next_s      = ST_QUARTER;
                    steps_left_next_s = QS_L;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_CONT: begin
                step_s = tick_s;
                if (!on_switch) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_CONT;
                end
            end
            ST_QUARTER: begin
                step_s = tick_s;
                if (on_switch) begin
                    state_next_s      = ST_CONT;
                    steps_left_next_s = 8'd0;
                end else if (tick_s) begin
                    steps_left_next_s = steps_left_r - 8'd1;
                    if (steps_left_r == 8'd1) begin
                        state_next_s = ST_HOLD;
                    end else begin
                        state_next_s = ST_QUARTER;
                    end
                end else begin
                    state_next_s = ST_QUARTER;
                end
            end
            ST_HOLD: begin
                if (on_switch) begin
                    state_next_s = ST_CONT;
                end else if (tick_s) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_HOLD;
                end
            end
            default: begin
                state_next_s      = ST_IDLE;
                steps_left_next_s = 8'd0;
            end
        endcase
    end

    // State, phase and registered driver outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r          <= ST_IDLE;
            phase_r          <= 2'd0;
            steps_left_r     <= 8'd0;
            qr_prev_r        <= 1'b0;
            coils_r          <= 4'b0000;
            step_pulse_r     <= 1'b0;
            quarter_active_r <= 1'b0;
        end else begin
            state_r          <= state_next_s;
            phase_r          <= phase_next_s;
            steps_left_r     <= steps_left_next_s;
            qr_prev_r        <= quarter_req;
            step_pulse_r     <= step_s;
            quarter_active_r <= (state_next_s == ST_QUARTER) || (state_next_s == ST_HOLD);
            // Coils stay energised through HOLD; the phase index survives idle periods.
            coils_r          <= (state_next_s != ST_IDLE) ? phase_coils(phase_next_s) : 4'b0000;
        end
    end

    assign coils          = coils_r;
    assign step_pulse     = step_pulse_r;
    assign quarter_active = quarter_active_r;
    assign motor_enable   = on_switch | quarter_active_r;
    assign steps_left     = steps_left_r;

endmodule

// File: tb/tb_motion_sequencer.sv
// Directed bench: two sequencers (divisor override, and a small speed table)
// with a per-instance step scoreboard of expected cycle and coil pattern.
module tb_motion_sequencer;

    typedef struct packed {
        int unsigned at;
        logic [3:0]  coils;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       on_switch;
    logic       quarter_req;
    logic       dir;
    logic [1:0] speed_sel;

    logic [3:0] coils0, coils1;
    logic       sp0, sp1, qa0, qa1, me0, me1;
    logic [7:0] sl0, sl1;

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   ph [2];
    exp_t q0 [$];
    exp_t q1 [$];
    logic [3:0] pt [4] = '{4'b0011, 4'b0110, 4'b1100, 4'b1001};

    motion_sequencer #(.QUARTER_STEPS(5), .TICK_DIV_OVR(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .on_switch(on_switch), .quarter_req(quarter_req),
        .dir(dir), .speed_sel(speed_sel), .coils(coils0), .step_pulse(sp0),
        .quarter_active(qa0), .motor_enable(me0), .steps_left(sl0)
    );

    motion_sequencer #(.QUARTER_STEPS(5), .TICK_DIV_OVR(0),
                       .SPEED_TABLE({20'd5, 20'd3, 20'd6, 20'd4})) u_dut_tbl (
        .clk(clk), .rst_n(rst_n), .on_switch(on_switch), .quarter_req(quarter_req),
        .dir(dir), .speed_sel(speed_sel), .coils(coils1), .step_pulse(sp1),
        .quarter_active(qa1), .motor_enable(me1), .steps_left(sl1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic exp_step(input int d, input int at, input bit fwd, input bit gated);
        exp_t e;
        ph[d]   = fwd ? (ph[d] + 1) % 4 : (ph[d] + 3) % 4;
        e.at    = at;
        e.coils = gated ? 4'b0000 : pt[ph[d]];
        if (d == 0) q0.push_back(e);
        else q1.push_back(e);
    endtask

    // Scoreboard pop on every step strobe of either instance
    always @(negedge clk) begin
        exp_t e;
        if (sp0) begin
            if (q0.size() == 0) check("dut0_unexpected_step", 32'(q0.size()), 32'd1);
            else begin
                e = q0.pop_front();
                check("dut0_step_cycle", 32'(cyc), e.at);
                check("dut0_step_coils", 32'(coils0), 32'(e.coils));
            end
        end
        if (sp1) begin
            if (q1.size() == 0) check("dut1_unexpected_step", 32'(q1.size()), 32'd1);
            else begin
                e = q1.pop_front();
                check("dut1_step_cycle", 32'(cyc), e.at);
                check("dut1_step_coils", 32'(coils1), 32'(e.coils));
            end
        end
    end

    task automatic queues_empty(input string tag);
        check({tag, "_q0_empty"}, 32'(q0.size()), 32'd0);
        check({tag, "_q1_empty"}, 32'(q1.size()), 32'd0);
    endtask

    task automatic run_quarter(input bit second_req);
        int e;
        int cnt;
        quarter_req = 1'b1;
        e = cyc + 1;
        for (int k = 1; k <= 5; k++) begin
            exp_step(0, e + 4 * k, 1'b1, 1'b0);
            exp_step(1, e + 4 * k, 1'b1, 1'b0);
        end
        cnt = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (i == 0) begin
                quarter_req = 1'b0;
                check("q_steps_load", 32'(sl0), 32'd5);
            end
            if (second_req && i == 4) quarter_req = 1'b1;
            if (i == 5) quarter_req = 1'b0;
            if (i == 8) check("q_steps_mid", 32'(sl0), 32'd3);
            if (qa0) cnt++;
        end
        check("q_active_len", 32'(cnt), 32'd24);
        check("q_coils_off", 32'(coils0), 32'd0);
        check("q_enable_off", 32'(me0), 32'd0);
        queues_empty("quarter");
    endtask

    initial begin
        int e;
        rst_n = 1'b0; on_switch = 1'b0; quarter_req = 1'b0; dir = 1'b1; speed_sel = 2'd0;
        ph[0] = 0; ph[1] = 0;
        repeat (3) @(negedge clk);
        check("rst_coils", 32'(coils0), 32'd0);
        check("rst_step_pulse", 32'(sp0), 32'd0);
        check("rst_quarter_active", 32'(qa0), 32'd0);
        check("rst_motor_enable", 32'(me0), 32'd0);
        check("rst_steps_left", 32'(sl0), 32'd0);
        check("rst_dut1_idle", 32'({coils1, qa1, me1, sl1}), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single quarter rotation, forward
        run_quarter(1'b0);

        // Continuous reverse motion for 40 cycles: 10 steps, the last on the exit edge
        dir = 1'b0;
        on_switch = 1'b1;
        e = cyc + 1;
        for (int k = 1; k <= 10; k++) begin
            exp_step(0, e + 4 * k, 1'b0, k == 10);
            exp_step(1, e + 4 * k, 1'b0, k == 10);
        end
        repeat (40) @(negedge clk);
        on_switch = 1'b0;
        #1;
        check("cont_enable_drop", 32'(me0), 32'd0);
        @(negedge clk);
        check("cont_coils_off", 32'(coils0), 32'd0);
        check("cont_phase_index", 32'(ph[0]), 32'd3);
        repeat (2) @(negedge clk);
        queues_empty("cont");

        // on_switch arrives on the second quarter step: switch to CONT without a gap
        dir = 1'b1;
        quarter_req = 1'b1;
        e = cyc + 1;
        for (int k = 1; k <= 4; k++) begin
            exp_step(0, e + 4 * k, 1'b1, 1'b0);
            exp_step(1, e + 4 * k, 1'b1, 1'b0);
        end
        @(negedge clk);
        quarter_req = 1'b0;
        repeat (7) @(negedge clk);
        check("abort_steps_before", 32'(sl0), 32'd4);
        on_switch = 1'b1;
        @(negedge clk);
        check("abort_steps_cleared", 32'(sl0), 32'd0);
        check("abort_quarter_active", 32'(qa0), 32'd0);
        repeat (9) @(negedge clk);
        on_switch = 1'b0;
        repeat (4) @(negedge clk);
        queues_empty("abort");

        // Second request during a quarter is discarded
        run_quarter(1'b1);

        // speed_sel change mid-period on the table-driven instance
        on_switch = 1'b1;
        e = cyc + 1;
        for (int k = 1; k <= 4; k++) exp_step(0, e + 4 * k, 1'b1, 1'b0);
        exp_step(1, e + 4, 1'b1, 1'b0);
        exp_step(1, e + 10, 1'b1, 1'b0);
        exp_step(1, e + 16, 1'b1, 1'b0);
        repeat (2) @(negedge clk);
        speed_sel = 2'd1;
        repeat (16) @(negedge clk);
        on_switch = 1'b0;
        repeat (3) @(negedge clk);
        speed_sel = 2'd0;
        check("speed_coils_off", 32'(coils1), 32'd0);
        queues_empty("speed");

        // Reset pulse in the middle of a quarter rotation
        quarter_req = 1'b1;
        e = cyc + 1;
        exp_step(0, e + 4, 1'b1, 1'b0);
        exp_step(1, e + 4, 1'b1, 1'b0);
        @(negedge clk);
        quarter_req = 1'b0;
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("arst_coils", 32'(coils0), 32'd0);
        check("arst_quarter_active", 32'(qa0), 32'd0);
        check("arst_motor_enable", 32'(me0), 32'd0);
        check("arst_steps_left", 32'(sl0), 32'd0);
        check("arst_dut1", 32'({coils1, qa1, sl1}), 32'd0);
        ph[0] = 0; ph[1] = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("arst_no_steps_coils", 32'(coils0), 32'd0);
        queues_empty("arst");

        // Restart after reset begins from phase 0
        run_quarter(1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/motion_sequencer.md
# motion_sequencer

Step-rate scheduler and mode sequencer for the stepper motor. It arbitrates between continuous motion (on_switch) and a one-shot quarter rotation (quarter_req) and generates the paced coil phase sequence in the selected direction. It drives quarter_active and motor_enable toward the motor driver and sits between the debounced board inputs and the coil driver pins.

## Interface
- QUARTER_STEPS, 50: full steps per quarter rotation (200-step motor); range 1..255
- TICK_DIV_OVR, 0: if nonzero, replaces every speed divisor (simulation speed-up)
- clk  in  1  system clock, 50 MHz
- rst_n  in  1  reset, asynchronous, active-low
- on_switch  in  1  continuous-motion request, level
- quarter_req  in  1  quarter-rotation request; the rising edge triggers
- dir  in  1  1 = forward (phase index +1), 0 = reverse (phase index −1)
- speed_sel  in  2  index into the speed divisor table
- coils  out  4  coil drive pattern A,B,A',B'
- step_pulse  out  1  one-cycle strobe coincident with each coil change
- quarter_active  out  1  high while a quarter rotation (including hold) is in progress
- motor_enable  out  1  driver enable
- steps_left  out  8  remaining steps in the current quarter rotation
- All inputs are debounced upstream and synchronous to clk.

## Operation
- States: IDLE, CONT, QUARTER, HOLD. Reset state is IDLE.
- IDLE: if on_switch=1, go to CONT. Otherwise, on a quarter_req rising edge, go to QUARTER and load steps_left=QUARTER_STEPS. on_switch has priority when both occur in the same cycle.
- CONT: step on every tick. When on_switch=0, go to IDLE on the next edge. quarter_req edges are ignored.
- QUARTER: on each tick, step and decrement steps_left. The tick that takes steps_left from 1 to 0 moves the block to HOLD. If on_switch=1, go to CONT immediately, abandon the remaining steps, and clear steps_left to 0.
- HOLD: wait one tick period with no step, then go to IDLE. If on_switch=1, go to CONT.
- quarter_active=1 in QUARTER and HOLD.
- motor_enable = on_switch | quarter_active. This is combinational.
- Phase index (2 bits, wraps mod 4) maps to coils:
  - 0 → 0011
  - 1 → 0110
  - 2 → 1100
  - 3 → 1001
- When motor_enable=0, coils=0000. The phase index is retained.
- Tick generator: divisor counter, 20 bits. It is cleared on every state entry and held at 0 in IDLE. A tick fires when the count equals DIV−1; the counter then wraps to 0.
- DIV comes from SPEED_DIV[speed_sel], or TICK_DIV_OVR if that is nonzero. It is latched at state entry and at each tick, so speed_sel changes take effect only at a period boundary.
- A quarter_req edge seen in any state other than IDLE is discarded and is not queued.

## Timing
- Reset values:
  - state=IDLE
  - phase=0
  - coils=0000
  - step_pulse=0
  - quarter_active=0
  - steps_left=0
  - divisor counter=0
  - quarter_req previous-value register=0
- The request sampled at edge E produces the state change at E. quarter_active is high from the cycle after E.
- The k-th step occurs k·DIV cycles after the state-entry edge. step_pulse and the new coils pattern are registered and appear together.
- A quarter rotation lasts (QUARTER_STEPS+1)·DIV cycles from entry until quarter_active falls. The +1 is the HOLD period.
- dir is sampled at each tick. A change between ticks affects only the next step.
- rst_n assertion mid-motion clears all outputs asynchronously. After deassertion the block restarts in IDLE.

## Structure
- Package motor_pkg holds:
  - the state enum type
  - SPEED_DIV[4] = 500000, 250000, 125000, 62500 (100/200/400/800 steps/s)
  - PHASE_TABLE[4]
  - DIV_W=20
- Sub-module step_tick_gen contains the divisor counter, the DIV latch and the tick output, with inputs clear and div.

## Test plan
- TICK_DIV_OVR=4, QUARTER_STEPS=5, dir=1, one pulse on quarter_req → coils step 0110, 1100, 1001, 0011, 0110 at 4-cycle spacing; five step_pulse strobes; quarter_active high for 24 cycles; then coils=0000.
- on_switch=1 for 40 cycles with dir=0 and DIV=4 → 10 steps; phase index goes 0→3→2→1→0 with wrap; after on_switch falls, motor_enable=0 and coils=0000 on the next edge.
- on_switch rises after step 2 of a quarter rotation → state CONT, steps_left=0, stepping continues with no gap longer than DIV.
- A second quarter_req edge during QUARTER → ignored; the total step count remains 5.
- speed_sel changes mid-period with TICK_DIV_OVR=0 and a forced small table → the new period is applied only from the next tick.
- rst_n pulsed low during QUARTER → all outputs return to reset values immediately and there are no further steps.
